adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive high cycles required on add_req to accept a request.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port add_req  input  1  add request level, active-high, already synchronised to clk.
REQ-005 SHALL have port sw1  input  8  operand A, unsigned.
REQ-006 SHALL have port sw2  input  8  operand B, unsigned.
REQ-007 SHALL have port busy  output  1  high while a request is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when new result is displayed.
REQ-009 SHALL have port carry  output  1  bit 8 of last sum.
REQ-010 SHALL have ports hex_d0, hex_d1, hex_d2  output  7 each  decimal ones/tens/hundreds of last sum, 7-segment, active-low, bit order gfedcba.

Function
REQ-011 SHALL generate one request event per accepted rising activation of add_req; add_req must return low before another event.
REQ-012 SHALL implement FSM states IDLE, CAPTURE, ADD, CONVERT, SHOW.
REQ-013 SHALL, with event in cycle E while IDLE, enter CAPTURE at E+1 and latch sw1, sw2 there.
REQ-014 SHALL enter ADD at E+2: 9-bit sum = {0,A} + {0,B}, no truncation.
REQ-015 SHALL perform CONVERT in exactly 9 cycles (E+3..E+11), shift-add-3 binary-to-BCD of the 9-bit sum into 3 digits (range 0..510).
REQ-016 SHALL enter SHOW at E+12: update hex_d0..2 and carry, assert done for that cycle only, return to IDLE at E+13.
REQ-017 SHALL assert busy from E+1 through E+12 inclusive; busy low in IDLE.
REQ-018 SHALL ignore (not queue) events occurring while busy; displayed result changes only in SHOW.
REQ-019 SHALL ignore sw1/sw2 changes after CAPTURE for the current operation.
REQ-020 SHALL display leading zeros (e.g. 7 shows 0,0,7).
REQ-021 SHALL encode digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-022 SHALL, on rst high at a clock edge, force IDLE, busy=0, done=0, carry=0, hex_d0..2=1000000, clear debounce counter and edge history.
REQ-023 SHALL abort any in-progress operation on reset without a done pulse; displayed result remains zero until a new complete operation.
REQ-024 SHALL not accept an event in the cycle rst is high; add_req held high through reset deassertion SHALL NOT generate an event until it goes low and high again.

Configuration
REQ-025 SHALL use macro ADDER_SEQ_DEBOUNCE_EN.
REQ-026 SHALL, with macro defined, generate event E on the cycle the debounce counter reaches DEBOUNCE_CYCLES consecutive high samples; any low sample clears the counter.
REQ-027 SHALL, without macro, generate event E on the cycle add_req is first sampled high after a low sample (single-cycle edge detect); DEBOUNCE_CYCLES unused.

Structure
REQ-028 SHALL place FSM state typedef, CONVERT iteration count (9), and digit segment constants in shared package adder_seq_pkg.
REQ-029 SHALL instantiate sub-module bcd_to_seg (4-bit BCD in, 7-bit active-low segments out, combinational) once per digit.
REQ-030 SHALL keep debounce/edge detect, FSM, and BCD shifter in adder_seq_ctrl.

Verification
REQ-031 SHALL test sw1=0x04, sw2=0x03, one request -> done at E+12, digits 0,0,7 (1000000,1000000,1111000), carry=0.
REQ-032 SHALL test sw1=0xF4, sw2=0xF3 -> sum 487, digits 4,8,7, carry=1.
REQ-033 SHALL test sw1=0xFF, sw2=0xFF -> digits 5,1,0, carry=1; then 0x00+0x00 -> 0,0,0, carry=0.
REQ-034 SHALL test second request pulse during CONVERT -> ignored, exactly one done pulse, busy low at E+13.
REQ-035 SHALL test rst asserted at E+6 -> no done, busy=0 next cycle, digits 1000000, carry=0.
REQ-036 SHALL test (macro defined, DEBOUNCE_CYCLES=4) add_req high 3 cycles then low -> no event; high 4 cycles -> exactly one event.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the sequential adder with BCD 7-segment display.
package adder_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ADD     = 3'd2,
    ST_CONVERT = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

  // One shift-add-3 iteration per bit of the 9-bit sum.
  localparam int CONV_ITERS = 9;

  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] bcd_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/adder_seq_bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment decoder (gfedcba).
module bcd_to_seg
  import adder_seq_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Request-driven 8+8 bit adder showing the 9-bit sum as three decimal 7-segment digits.
// Define ADDER_SEQ_DEBOUNCE_EN to require DEBOUNCE_CYCLES consecutive high samples per request.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add_req,
  input  logic [7:0] sw1,
  input  logic [7:0] sw2,
  output logic       busy,
  output logic       done,
  output logic       carry,
  output logic [6:0] hex_d0,
  output logic [6:0] hex_d1,
  output logic [6:0] hex_d2,
  output logic [2:0] state_dbg
);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [20:0] shift_q, shift_d;
  logic [3:0]  iter_q, iter_d;
  logic [11:0] disp_q, disp_d;
  logic        carry_q, carry_d;
  logic        carry_pend_q, carry_pend_d;
  logic        armed_q, armed_d;
  logic        req_event;
  logic [8:0]  sum_ab;
  logic [11:0] bcd_adjusted;
  logic [20:0] shift_step;

  // armed_q is the edge history: a low sample is needed before any new request,
  // so a level held high through reset never fires.
  always_comb begin
    armed_d = add_req ? (armed_q & ~req_event) : 1'b1;
  end

`ifdef ADDER_SEQ_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (!add_req) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_W'(DEBOUNCE_CYCLES)) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  assign req_event = armed_q & add_req & (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) deb_cnt_q <= '0;
    else     deb_cnt_q <= deb_cnt_d;
  end
`else
  assign req_event = armed_q & add_req;
`endif

  assign sum_ab       = {1'b0, a_q} + {1'b0, b_q};
  assign bcd_adjusted = {bcd_adj(shift_q[20:17]), bcd_adj(shift_q[16:13]), bcd_adj(shift_q[12:9])};
  assign shift_step   = {bcd_adjusted, shift_q[8:0]} << 1;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    shift_d      = shift_q;
    iter_d       = iter_q;
    disp_d       = disp_q;
    carry_d      = carry_q;
    carry_pend_d = carry_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (req_event) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        a_d     = sw1;
        b_d     = sw2;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        shift_d      = {12'd0, sum_ab};
        carry_pend_d = sum_ab[8];
        iter_d       = 4'd0;
        state_d      = ST_CONVERT;
      end
      ST_CONVERT: begin
        shift_d = shift_step;
        iter_d  = iter_q + 4'd1;
        // The display is loaded on the final iteration so it is valid during SHOW.
        if (iter_q == 4'(CONV_ITERS - 1)) begin
          disp_d  = shift_step[20:9];
          carry_d = carry_pend_q;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      shift_q      <= '0;
      iter_q       <= '0;
      disp_q       <= '0;
      carry_q      <= 1'b0;
      carry_pend_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      shift_q      <= shift_d;
      iter_q       <= iter_d;
      disp_q       <= disp_d;
      carry_q      <= carry_d;
      carry_pend_q <= carry_pend_d;
      armed_q      <= armed_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_SHOW);
  assign carry     = carry_q;
  assign state_dbg = state_q;

  bcd_to_seg u_seg_d0 (.bcd(disp_q[3:0]),  .seg(hex_d0));
  bcd_to_seg u_seg_d1 (.bcd(disp_q[7:4]),  .seg(hex_d1));
  bcd_to_seg u_seg_d2 (.bcd(disp_q[11:8]), .seg(hex_d2));

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed testbench for adder_seq_ctrl; build with ADDER_SEQ_DEBOUNCE_EN for the debounce case.
module tb_adder_seq_ctrl;

  localparam int DEB = 4;
`ifdef ADDER_SEQ_DEBOUNCE_EN
  localparam int REQ_HOLD = DEB;
`else
  localparam int REQ_HOLD = 1;
`endif

  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       rst;
  logic       add_req;
  logic [7:0] sw1, sw2;
  logic       busy, done, carry;
  logic [6:0] hex_d0, hex_d1, hex_d2;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .add_req(add_req), .sw1(sw1), .sw2(sw2),
    .busy(busy), .done(done), .carry(carry),
    .hex_d0(hex_d0), .hex_d1(hex_d1), .hex_d2(hex_d2), .state_dbg(state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input int h, input int t, input int o, input logic c);
    check({tag, "_hex_d2"}, 16'(hex_d2), 16'(SEG[h]));
    check({tag, "_hex_d1"}, 16'(hex_d1), 16'(SEG[t]));
    check({tag, "_hex_d0"}, 16'(hex_d0), 16'(SEG[o]));
    check({tag, "_carry"},  16'(carry),  16'(c));
  endtask

  // Raises add_req so that the accepted event lands in cycle E, then walks E..E+13.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int h, input int t, input int o, input logic c,
                        input bit inject, input bit do_rst);
    sw1 = a;
    sw2 = b;
    add_req = 1'b1;
    for (int p = 0; p < REQ_HOLD - 1; p++) begin
      check({tag, "_pre_busy"}, 16'(busy), 16'd0);
      tick();
    end
    check({tag, "_e0_busy"}, 16'(busy), 16'd0);
    tick();
    add_req = 1'b0;
    check({tag, "_e1_busy"}, 16'(busy), 16'd1);
    check({tag, "_e1_done"}, 16'(done), 16'd0);
    tick();
    sw1 = ~a;
    sw2 = a ^ 8'h5A;
    for (int k = 2; k <= 11; k++) begin
      if (inject && k == 5) add_req = 1'b1;
      if (inject && k == 5 + REQ_HOLD) add_req = 1'b0;
      if (do_rst && k == 7) begin
        rst = 1'b0;
        check({tag, "_rst_busy"}, 16'(busy), 16'd0);
        check({tag, "_rst_done"}, 16'(done), 16'd0);
        check_disp({tag, "_rst"}, 0, 0, 0, 1'b0);
        for (int q = 0; q < 10; q++) begin
          tick();
          check({tag, "_post_rst_done"}, 16'(done), 16'd0);
          check({tag, "_post_rst_busy"}, 16'(busy), 16'd0);
        end
        check_disp({tag, "_post_rst"}, 0, 0, 0, 1'b0);
        return;
      end
      if (do_rst && k == 6) rst = 1'b1;
      check({tag, "_run_busy"}, 16'(busy), 16'd1);
      check({tag, "_run_done"}, 16'(done), 16'd0);
      tick();
    end
    check({tag, "_e12_done"}, 16'(done), 16'd1);
    check({tag, "_e12_busy"}, 16'(busy), 16'd1);
    check_disp({tag, "_e12"}, h, t, o, c);
    tick();
    check({tag, "_e13_done"}, 16'(done), 16'd0);
    check({tag, "_e13_busy"}, 16'(busy), 16'd0);
    check_disp({tag, "_e13"}, h, t, o, c);
    if (inject) begin
      for (int q = 0; q < 16; q++) begin
        tick();
        check({tag, "_after_done"}, 16'(done), 16'd0);
        check({tag, "_after_busy"}, 16'(busy), 16'd0);
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    add_req = 1'b0;
    sw1 = 8'h00;
    sw2 = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_done", 16'(done), 16'd0);
    check_disp("reset", 0, 0, 0, 1'b0);

    run_op("sum7",   8'h04, 8'h03, 0, 0, 7, 1'b0, 1'b0, 1'b0);
    run_op("sum487", 8'hF4, 8'hF3, 4, 8, 7, 1'b1, 1'b0, 1'b0);
    run_op("sum510", 8'hFF, 8'hFF, 5, 1, 0, 1'b1, 1'b0, 1'b0);
    run_op("sum0",   8'h00, 8'h00, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_op("inject", 8'h12, 8'h34, 0, 7, 0, 1'b0, 1'b1, 1'b0);
    run_op("abort",  8'h64, 8'h64, 2, 0, 0, 1'b0, 1'b0, 1'b1);

    // add_req held high through reset must not start an operation.
    rst = 1'b1;
    add_req = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int q = 0; q < 10; q++) begin
      tick();
      check("held_busy", 16'(busy), 16'd0);
    end
    add_req = 1'b0;
    tick();
    check_disp("held", 0, 0, 0, 1'b0);

`ifdef ADDER_SEQ_DEBOUNCE_EN
    add_req = 1'b1;
    repeat (DEB - 1) tick();
    add_req = 1'b0;
    for (int q = 0; q < 8; q++) begin
      tick();
      check("short_busy", 16'(busy), 16'd0);
    end
`endif

    run_op("sum256", 8'h80, 8'h80, 2, 5, 6, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
